// File: rtl/shape_point_sequencer.sv
// Shape point sequencer: accepts one shape instruction (three vertices plus a
// shape code), derives the fourth vertex of a parallelogram with clamping to
// the grid, then streams the vertices one per cycle under valid/ready flow
// control. Returning to idle after the last vertex costs one cycle.

`timescale 1ns/1ps

module shape_point_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Instruction side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_shape,
  input  logic [3*WIDTH-1:0]    in_x,
  input  logic [3*HEIGHT-1:0]   in_y,
  // Vertex stream
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [WIDTH-1:0]      pt_x,
  output logic [HEIGHT-1:0]     pt_y,
  output logic [1:0]            pt_idx,
  output logic                  pt_last,
  output logic                  pt_clip,
  // Status
  output logic                  err_shape,
  output logic [CNT_W-1:0]      shape_cnt
);

  localparam logic [1:0] ShapeTri  = 2'd0;
  localparam logic [1:0] ShapePara = 2'd1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e state_q;

  // Vertex store, entry 0 = P1 ... entry 3 = P4
  logic [3:0][WIDTH-1:0]  vx_q;
  logic [3:0][HEIGHT-1:0] vy_q;
  logic                   para_q;
  logic                   clip4_q;

  // P4 derivation
  logic [WIDTH+1:0]  x4_raw;
  logic [HEIGHT+1:0] y4_raw;
  logic [WIDTH-1:0]  x4;
  logic [HEIGHT-1:0] y4;
  logic              x4_clip;
  logic              y4_clip;

  // Sequencing helpers
  logic [1:0] idx_nxt;
  logic       last_nxt;
  logic       shape_ok;

  // P4 = P1 + P3 - P2 at two extra bits; the top bit flags a negative result
  // and the next bit flags overflow past the grid edge.
  always_comb begin
    x4_raw = {2'b00, in_x[WIDTH-1:0]} + {2'b00, in_x[3*WIDTH-1:2*WIDTH]}
           - {2'b00, in_x[2*WIDTH-1:WIDTH]};
    y4_raw = {2'b00, in_y[HEIGHT-1:0]} + {2'b00, in_y[3*HEIGHT-1:2*HEIGHT]}
           - {2'b00, in_y[2*HEIGHT-1:HEIGHT]};

    x4_clip = x4_raw[WIDTH+1] | x4_raw[WIDTH];
    if (x4_raw[WIDTH+1]) begin
      x4 = '0;
    end else if (x4_raw[WIDTH]) begin
      x4 = '1;
    end else begin
      x4 = x4_raw[WIDTH-1:0];
    end

    y4_clip = y4_raw[HEIGHT+1] | y4_raw[HEIGHT];
    if (y4_raw[HEIGHT+1]) begin
      y4 = '0;
    end else if (y4_raw[HEIGHT]) begin
      y4 = '1;
    end else begin
      y4 = y4_raw[HEIGHT-1:0];
    end
  end

  // Next vertex selection while emitting
  always_comb begin
    idx_nxt  = pt_idx + 2'd1;
    last_nxt = para_q ? (idx_nxt == 2'd3) : (idx_nxt == 2'd2);
    shape_ok = (in_shape == ShapeTri) || (in_shape == ShapePara);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      pt_valid  <= 1'b0;
      pt_x      <= '0;
      pt_y      <= '0;
      pt_idx    <= 2'd0;
      pt_last   <= 1'b0;
      pt_clip   <= 1'b0;
      err_shape <= 1'b0;
      shape_cnt <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      para_q    <= 1'b0;
      clip4_q   <= 1'b0;
    end else begin
      err_shape <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (shape_ok) begin
              vx_q     <= {x4, in_x};
              vy_q     <= {y4, in_y};
              para_q   <= (in_shape == ShapePara);
              clip4_q  <= x4_clip | y4_clip;
              state_q  <= StEmit;
              in_ready <= 1'b0;
              pt_valid <= 1'b1;
              pt_x     <= in_x[WIDTH-1:0];
              pt_y     <= in_y[HEIGHT-1:0];
              pt_idx   <= 2'd0;
              pt_last  <= 1'b0;
              pt_clip  <= 1'b0;
            end else begin
              // Reserved code: consume the instruction and flag it, emit nothing
              err_shape <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (pt_ready) begin
            if (pt_last) begin
              shape_cnt <= shape_cnt + 1'b1;
              state_q   <= StIdle;
              in_ready  <= 1'b1;
              pt_valid  <= 1'b0;
              pt_x      <= '0;
              pt_y      <= '0;
              pt_idx    <= 2'd0;
              pt_last   <= 1'b0;
              pt_clip   <= 1'b0;
            end else begin
              pt_idx  <= idx_nxt;
              pt_x    <= vx_q[idx_nxt];
              pt_y    <= vy_q[idx_nxt];
              pt_last <= last_nxt;
              pt_clip <= (idx_nxt == 2'd3) && clip4_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A stalled vertex must hold still until it is taken
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    pt_valid && !pt_ready |=> pt_valid && $stable(pt_x) && $stable(pt_y) &&
                             $stable(pt_idx) && $stable(pt_last) && $stable(pt_clip));

  // Acceptance never overlaps emission
  a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && pt_valid));

endmodule

// File: tb/tb_shape_point_sequencer.sv
// Directed bench for shape_point_sequencer: a table of instructions with
// hand-computed vertex streams, plus sequences for backpressure, reserved
// codes, mid-shape reset and counter wrap (second instance with CNT_W=2).

`timescale 1ns/1ps

module tb_shape_point_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_shape;
  logic [11:0] in_x;
  logic [8:0]  in_y;
  logic        pt_valid;
  logic        pt_ready;
  logic [3:0]  pt_x;
  logic [2:0]  pt_y;
  logic [1:0]  pt_idx;
  logic        pt_last;
  logic        pt_clip;
  logic        err_shape;
  logic [7:0]  shape_cnt;

  logic        d2_in_ready;
  logic        d2_pt_valid;
  logic [3:0]  d2_pt_x;
  logic [2:0]  d2_pt_y;
  logic [1:0]  d2_pt_idx;
  logic        d2_pt_last;
  logic        d2_pt_clip;
  logic        d2_err_shape;
  logic [1:0]  d2_shape_cnt;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  shape_point_sequencer #(.WIDTH(4), .HEIGHT(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_shape(in_shape), .in_x(in_x), .in_y(in_y),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_idx(pt_idx),
    .pt_last(pt_last), .pt_clip(pt_clip), .err_shape(err_shape), .shape_cnt(shape_cnt)
  );

  shape_point_sequencer #(.WIDTH(4), .HEIGHT(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_shape(in_shape), .in_x(in_x),
    .in_y(in_y), .pt_valid(d2_pt_valid), .pt_ready(pt_ready), .pt_x(d2_pt_x),
    .pt_y(d2_pt_y), .pt_idx(d2_pt_idx), .pt_last(d2_pt_last), .pt_clip(d2_pt_clip),
    .err_shape(d2_err_shape), .shape_cnt(d2_shape_cnt)
  );

  typedef struct {
    logic [1:0]  shape;
    logic [11:0] x;     // {x3,x2,x1}
    logic [8:0]  y;     // {y3,y2,y1}
    int          n;     // expected vertex count, 0 for reserved
    logic [15:0] ex;    // {x4,x3,x2,x1}
    logic [11:0] ey;    // {y4,y3,y2,y1}
    logic        clip;  // expected pt_clip on idx 3
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_idle(input string tag, input int cnt);
    chk({tag, "_pt_valid"}, pt_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_cnt"}, shape_cnt, cnt % 256);
    chk({tag, "_cnt_w2"}, d2_shape_cnt, cnt % 4);
  endtask

  // Present one instruction from an idle negedge, then follow its vertex stream.
  // Returns at the negedge after the final handshake (or after the error pulse).
  task automatic run_shape(input string tag, input vec_t v, input int stall_idx,
                           input int stall_cyc);
    int stalls;
    chk({tag, "_accept_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_shape = v.shape;
    in_x     = v.x;
    in_y     = v.y;
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = ~v.x;
    in_y     = ~v.y;
    if (v.n == 0) begin
      chk({tag, "_err_pulse"}, err_shape, 1);
      chk_idle(tag, exp_cnt);
    end else begin
      for (int i = 0; i < v.n; i++) begin
        stalls = (i == stall_idx) ? stall_cyc : 0;
        for (int s = 0; s <= stalls; s++) begin
          string t;
          t = $sformatf("%s_v%0d_c%0d", tag, i, s);
          chk({t, "_valid"}, pt_valid, 1);
          chk({t, "_x"}, pt_x, v.ex[4*i +: 4]);
          chk({t, "_y"}, pt_y, v.ey[3*i +: 3]);
          chk({t, "_idx"}, pt_idx, i);
          chk({t, "_last"}, pt_last, (i == v.n - 1) ? 1 : 0);
          chk({t, "_clip"}, pt_clip, (i == 3) ? v.clip : 0);
          chk({t, "_in_ready"}, in_ready, 0);
          chk({t, "_err"}, err_shape, 0);
          pt_ready = (s == stalls);
          @(negedge clk);
        end
      end
      exp_cnt++;
      chk_idle({tag, "_done"}, exp_cnt);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, {4'd5, 4'd3, 4'd1}, {3'd4, 3'd1, 3'd1}, 3,
                {4'd0, 4'd5, 4'd3, 4'd1}, {3'd0, 3'd4, 3'd1, 3'd1}, 1'b0};
    vecs[1] = '{2'd1, {4'd5, 4'd3, 4'd1}, {3'd4, 3'd1, 3'd1}, 4,
                {4'd3, 4'd5, 4'd3, 4'd1}, {3'd4, 3'd4, 3'd1, 3'd1}, 1'b0};
    vecs[2] = '{2'd1, {4'd2, 4'd5, 4'd0}, {3'd3, 3'd0, 3'd0}, 4,
                {4'd0, 4'd2, 4'd5, 4'd0}, {3'd3, 3'd3, 3'd0, 3'd0}, 1'b1};
    vecs[3] = '{2'd1, {4'd15, 4'd0, 4'd15}, {3'd7, 3'd0, 3'd7}, 4,
                {4'd15, 4'd15, 4'd0, 4'd15}, {3'd7, 3'd7, 3'd0, 3'd7}, 1'b1};
    vecs[4] = '{2'd2, {4'd1, 4'd2, 4'd3}, {3'd1, 3'd2, 3'd3}, 0, 16'd0, 12'd0, 1'b0};
    vecs[5] = '{2'd0, {4'd8, 4'd15, 4'd0}, {3'd3, 3'd0, 3'd7}, 3,
                {4'd0, 4'd8, 4'd15, 4'd0}, {3'd0, 3'd3, 3'd0, 3'd7}, 1'b0};
    vecs[6] = '{2'd3, {4'd9, 4'd9, 4'd9}, {3'd2, 3'd2, 3'd2}, 0, 16'd0, 12'd0, 1'b0};
    vecs[7] = '{2'd1, {4'd0, 4'd15, 4'd15}, {3'd7, 3'd7, 3'd0}, 4,
                {4'd0, 4'd0, 4'd15, 4'd15}, {3'd0, 3'd7, 3'd7, 3'd0}, 1'b0};
    vecs[8] = '{2'd1, {4'd0, 4'd0, 4'd15}, {3'd0, 3'd0, 3'd7}, 4,
                {4'd15, 4'd0, 4'd0, 4'd15}, {3'd7, 3'd0, 3'd0, 3'd7}, 1'b0};
    vecs[9] = '{2'd1, {4'd4, 4'd3, 4'd2}, {3'd5, 3'd0, 3'd6}, 4,
                {4'd3, 4'd4, 4'd3, 4'd2}, {3'd7, 3'd5, 3'd0, 3'd6}, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_shape = 2'd0;
    in_x     = '0;
    in_y     = '0;
    pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_pt_x", pt_x, 0);
    chk("rst_pt_y", pt_y, 0);
    chk("rst_pt_idx", pt_idx, 0);
    chk("rst_pt_last", pt_last, 0);
    chk("rst_pt_clip", pt_clip, 0);
    chk("rst_err", err_shape, 0);
    chk_idle("rst", 0);

    // Table: back-to-back instructions with continuous pt_ready
    for (int k = 0; k < NV; k++) begin
      run_shape($sformatf("t%0d", k), vecs[k], -1, 0);
    end

    // Backpressure: three stall cycles on idx 1
    run_shape("bp", vecs[0], 1, 3);

    // Async reset during idx 2 of a parallelogram
    in_valid = 1'b1;
    in_shape = vecs[1].shape;
    in_x     = vecs[1].x;
    in_y     = vecs[1].y;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_idx_before", pt_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pt_valid", pt_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_pt_x", pt_x, 0);
    chk("ar_pt_y", pt_y, 0);
    chk("ar_pt_idx", pt_idx, 0);
    chk("ar_pt_last", pt_last, 0);
    chk("ar_cnt", shape_cnt, 0);
    chk("ar_cnt_w2", d2_shape_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("ar_post%0d_valid", c), pt_valid, 0);
      chk($sformatf("ar_post%0d_cnt", c), shape_cnt, 0);
    end

    // Normal operation after reset
    run_shape("post", vecs[1], -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shape_point_sequencer.md
Name: shape_point_sequencer

Overview:
Accepts one shape instruction (three vertices plus shape code) over a valid/ready handshake. For parallelograms it derives the fourth vertex as P4 = P1 + P3 - P2, with clamping to the coordinate grid. It then streams the shape's vertices one per cycle, with backpressure, to the downstream rasteriser/fill stage. It replaces the combinational packed-points path with a pipelined, parametrised, flow-controlled stage.

Parameters:
WIDTH, 4, bits per x coordinate (grid columns = 2^WIDTH)
HEIGHT, 3, bits per y coordinate (grid rows = 2^HEIGHT)
CNT_W, 8, width of completed-shape counter

Ports:
clk  in  1  clock, all flops rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  block can accept instruction
in_shape  in  2  0 = triangle, 1 = parallelogram, 2/3 = reserved
in_x  in  3*WIDTH  {x3,x2,x1}, x1 in LSBs
in_y  in  3*HEIGHT  {y3,y2,y1}, y1 in LSBs
pt_valid  out  1  vertex valid
pt_ready  in  1  downstream accepts vertex
pt_x  out  WIDTH  vertex x
pt_y  out  HEIGHT  vertex y
pt_idx  out  2  vertex index 0..3
pt_last  out  1  final vertex of current shape
pt_clip  out  1  this vertex was clamped
err_shape  out  1  one-cycle pulse: reserved shape code consumed
shape_cnt  out  CNT_W  shapes fully emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1; pt_valid=0; pt_x/pt_y/pt_idx/pt_last/pt_clip=0; err_shape=0; shape_cnt=0. A reset mid-shape abandons the shape with no further vertices and no count.
- FSM states IDLE, EMIT.
- IDLE: in_ready=1. On in_valid&&in_ready, register vertices and shape. For shape 1, compute P4 in the same cycle.
  - Shape 0 or 1: go to EMIT. pt_valid=1 with idx 0 on the next cycle (1-cycle latency).
  - Shape 2/3: stay IDLE, pulse err_shape for one cycle, emit nothing, leave shape_cnt unchanged.
- EMIT: in_ready=0. The current vertex is presented. pt_x/pt_y/pt_idx/pt_last/pt_clip stay stable while pt_valid&&!pt_ready.
  - On pt_valid&&pt_ready:
    - If pt_last: increment shape_cnt, go to IDLE, pt_valid=0 next cycle.
    - Otherwise: idx+1, next vertex on the next cycle.
  - No bubble between vertices under continuous pt_ready.
- Vertex order: P1, P2, P3, then P4 (parallelogram only).
  - pt_last is 1 on idx 2 for a triangle and on idx 3 for a parallelogram.
  - pt_clip is 0 for idx 0..2.
- P4 arithmetic:
  - x4 = x1 + x3 - x2, evaluated signed at WIDTH+2 bits. If <0, clamp to 0. If >2^WIDTH-1, clamp to 2^WIDTH-1.
  - y4 is computed the same way at HEIGHT+2 bits.
  - pt_clip=1 on idx 3 if either coordinate clamped.
- Throughput: one shape per (N+1) cycles minimum, where N = vertex count, because the return to IDLE costs one cycle. Next-instruction acceptance is not overlapped with the last vertex.
- in_valid is ignored while in_ready=0. Upstream holds its data until the handshake occurs.
- shape_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Triangle, defaults: x={5,3,1}, y={4,1,1}, continuous pt_ready -> 3 consecutive vertices (1,1),(3,1),(5,4); idx 0,1,2; pt_last only on idx 2; shape_cnt=1; in_ready returns 1 one cycle after the last vertex.
- Parallelogram, same vertices -> 4 vertices, P4=(3,4), pt_clip=0, pt_last on idx 3; shape_cnt increments by 1.
- Clamping: P1=(0,0), P2=(5,0), P3=(2,3) -> P4=(0,3), pt_clip=1. Separately P1=(15,7), P2=(0,0), P3=(15,7) -> P4=(15,7), pt_clip=1.
- Backpressure: pt_ready low for 3 cycles on idx 1 -> pt_valid stays 1 and outputs stay frozen; the sequence resumes without loss or duplication; in_ready stays 0 throughout.
- Reserved shape 2 -> err_shape high exactly one cycle, pt_valid never asserts, shape_cnt unchanged, next instruction accepted the following cycle.
- Async reset asserted during idx 2 of a parallelogram -> all outputs at reset values immediately; no P4 after release; shape_cnt=0. With CNT_W=2, 4 shapes -> shape_cnt wraps to 0.
